// File: rtl/pipeline_pkg.sv
// Shared encodings for the hazard/stall sequencer: FSM states, NOP, register zero
// and the counter-width helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_MD_DONE = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    function automatic int md_cnt_width(input int latency);
        return ($clog2(latency) < 1) ? 1 : $clog2(latency);
    endfunction

    // True when the producer register rd feeds a source of the ID instruction.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic rt_used);
        return (rd != REG_ZERO) && ((rd == rs) || (rt_used && (rd == rt)));
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter timing the mul/div freeze: load, decrement, zero flag.
module md_latency_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand stall detection and mul/div front-end freeze sequencer.
// Optional performance counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = 32
`ifdef HAZARD_STATS_EN
   ,parameter int STAT_W     = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_RS,
    input  logic [4:0] ID_RT,
    input  logic       ID_RT_Used,
    input  logic       ID_Branch,
    input  logic       ID_BranchTaken,
    input  logic [4:0] ID_EX_RD,
    input  logic       ID_EX_RegWrite,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_MulDiv,
    input  logic [4:0] EX_MEM_RD,
    input  logic       EX_MEM_MemRead,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Write,
    output logic       ID_EX_Bubble,
    output logic       EX_MEM_Bubble,
    output logic       MD_Start,
    output logic       MD_Busy
`ifdef HAZARD_STATS_EN
   ,output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
`endif
);

    localparam int CNT_W = md_cnt_width(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

    state_e state_q, state_d;
    logic   cnt_load, cnt_dec, cnt_zero;
    logic   load_use, branch_stall;

    md_latency_counter #(.W(CNT_W)) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_LOAD),
        .zero     (cnt_zero)
    );

    assign load_use     = ID_EX_MemRead && src_match(ID_EX_RD, ID_RS, ID_RT, ID_RT_Used);
    assign branch_stall = ID_Branch &&
                          ((ID_EX_RegWrite && src_match(ID_EX_RD, ID_RS, ID_RT, ID_RT_Used)) ||
                           (EX_MEM_MemRead && src_match(EX_MEM_RD, ID_RS, ID_RT, ID_RT_Used)));

    always_comb begin
        state_d       = state_q;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MD_Start      = 1'b0;
        MD_Busy       = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        unique case (state_q)
            ST_RUN, ST_MD_DONE: begin
                // In MD_DONE the op is still in EX; it must leave, not restart.
                if ((state_q == ST_RUN) && ID_EX_MulDiv) begin
                    PC_Write      = 1'b0;
                    IF_ID_Write   = 1'b0;
                    ID_EX_Write   = 1'b0;
                    EX_MEM_Bubble = 1'b1;
                    MD_Start      = 1'b1;
                    MD_Busy       = 1'b1;
                    cnt_load      = 1'b1;
                    state_d       = ST_MD_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (load_use || branch_stall) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end else begin
                        IF_ID_Flush  = ID_BranchTaken;
                    end
                end
            end
            ST_MD_WAIT: begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Bubble = 1'b1;
                MD_Busy       = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_MD_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (rst) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            IF_ID_Flush   = 1'b0;
            ID_EX_Write   = 1'b0;
            ID_EX_Bubble  = 1'b0;
            EX_MEM_Bubble = 1'b0;
            MD_Start      = 1'b0;
            MD_Busy       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [STAT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!rst && !PC_Write && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (IF_ID_Flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: driver pushes model expectations,
// a negedge monitor pops and compares. Honours HAZARD_STATS_EN.
module tb_hazard_stall_controller;

    localparam int L  = 4;
    localparam int SW = 8;
    localparam int SAT = (1 << SW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ID_RS = '0, ID_RT = '0, ID_EX_RD = '0, EX_MEM_RD = '0;
    logic       ID_RT_Used = 0, ID_Branch = 0, ID_BranchTaken = 0;
    logic       ID_EX_RegWrite = 0, ID_EX_MemRead = 0, ID_EX_MulDiv = 0, EX_MEM_MemRead = 0;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
    logic       ID_EX_Bubble, EX_MEM_Bubble, MD_Start, MD_Busy;
`ifdef HAZARD_STATS_EN
    logic [SW-1:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MD_LATENCY (L)
`ifdef HAZARD_STATS_EN
       ,.STAT_W     (SW)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RT_Used(ID_RT_Used),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
        .ID_EX_RD(ID_EX_RD), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MulDiv(ID_EX_MulDiv),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_MemRead(EX_MEM_MemRead),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .EX_MEM_Bubble(EX_MEM_Bubble), .MD_Start(MD_Start), .MD_Busy(MD_Busy)
`ifdef HAZARD_STATS_EN
       ,.stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, ex_rd, mem_rd;
        logic       rt_used, br, taken, ex_rw, ex_mr, ex_md, mem_mr;
    } in_t;

    // outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, MD_Start, MD_Busy}
    typedef struct {
        logic [7:0] outs;
        int         sc;
        int         fc;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: freeze cycles still owed, and "op just finished" marker.
    int   md_left  = 0;
    bit   after_md = 0;
    int   sc_m     = 0;
    int   fc_m     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s.rst = 0; s.rs = 0; s.rt = 0; s.ex_rd = 0; s.mem_rd = 0;
        s.rt_used = 0; s.br = 0; s.taken = 0; s.ex_rw = 0; s.ex_mr = 0; s.ex_md = 0; s.mem_mr = 0;
        return s;
    endfunction

    function automatic bit reads(input logic [4:0] r, input in_t s);
        return (r != 0) && (r == s.rs || (s.rt_used && r == s.rt));
    endfunction

    task automatic step(input in_t s, input string tag);
        exp_t e;
        bit   freeze, start, stall, flush;
        @(posedge clk); #1;
        rst = s.rst; ID_RS = s.rs; ID_RT = s.rt; ID_RT_Used = s.rt_used;
        ID_Branch = s.br; ID_BranchTaken = s.taken;
        ID_EX_RD = s.ex_rd; ID_EX_RegWrite = s.ex_rw; ID_EX_MemRead = s.ex_mr; ID_EX_MulDiv = s.ex_md;
        EX_MEM_RD = s.mem_rd; EX_MEM_MemRead = s.mem_mr;

        e.tag = tag;
        if (s.rst) begin
            e.outs = '0; e.sc = 0; e.fc = 0;
            md_left = 0; after_md = 0; sc_m = 0; fc_m = 0;
        end else begin
            e.sc = sc_m; e.fc = fc_m;
            freeze = 0; start = 0;
            if (md_left > 0) begin
                freeze = 1;
                md_left--;
                if (md_left == 0) after_md = 1;
            end else if (!after_md && s.ex_md) begin
                freeze = 1; start = 1; md_left = L - 1;
            end else begin
                after_md = 0;
            end
            if (freeze) begin
                e.outs = {4'b0000, 1'b0, 1'b1, start, 1'b1};
            end else begin
                stall = (s.ex_mr && reads(s.ex_rd, s)) ||
                        (s.br && ((s.ex_rw && reads(s.ex_rd, s)) || (s.mem_mr && reads(s.mem_rd, s))));
                flush = !stall && s.taken;
                e.outs = {!stall, !stall, flush, 1'b1, stall, 3'b000};
            end
            if (!e.outs[7] && sc_m < SAT) sc_m++;
            if (e.outs[5] && fc_m < SAT) fc_m++;
        end
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ":outs"},
                      {56'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                       ID_EX_Bubble, EX_MEM_Bubble, MD_Start, MD_Busy}, {56'd0, e.outs});
`ifdef HAZARD_STATS_EN
                check({e.tag, ":stall_cycles"}, 64'(stall_cycles), 64'(e.sc));
                check({e.tag, ":flush_count"},  64'(flush_count),  64'(e.fc));
`endif
            end
        end
    end

    initial begin : driver
        in_t s;
        s = idle(); s.rst = 1;
        step(s, "reset");
        step(s, "reset");

        s = idle();
        step(s, "default");
        s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 2; s.rs = 2; s.rt = 4; s.rt_used = 1;
        step(s, "load_use");
        s = idle();
        step(s, "after_load_use");
        s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 0; s.rs = 0; s.rt = 0; s.rt_used = 1;
        step(s, "load_r0");

        s = idle(); s.br = 1; s.rs = 5; s.rt = 6; s.rt_used = 1; s.ex_rd = 5; s.ex_rw = 1; s.taken = 1;
        step(s, "branch_stall");
        s.ex_rw = 0;
        step(s, "branch_flush");

        s = idle(); s.ex_md = 1;
        for (int i = 0; i < L + 1; i++) step(s, "mult");
        s = idle();
        step(s, "after_mult");

        s = idle(); s.ex_md = 1;
        step(s, "mult_a");
        step(s, "mult_a");
        s.rst = 1;
        step(s, "mult_rst");
        s = idle(); s.ex_md = 1;
        for (int i = 0; i < L + 1; i++) step(s, "mult_b");
        s = idle(); s.ex_mr = 1; s.ex_rd = 3; s.rs = 3;
        step(s, "load_use_b");
        s = idle(); s.taken = 1;
        step(s, "flush_b");

        for (int n = 0; n < 3000; n++) begin
            s.rst     = ($urandom_range(0, 63) == 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.ex_rd   = 5'($urandom_range(0, 3));
            s.mem_rd  = 5'($urandom_range(0, 3));
            s.rt_used = 1'($urandom);
            s.br      = 1'($urandom);
            s.taken   = 1'($urandom);
            s.ex_rw   = 1'($urandom);
            s.ex_mr   = 1'($urandom);
            s.mem_mr  = 1'($urandom);
            s.ex_md   = ($urandom_range(0, 11) == 0);
            step(s, "random");
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
